cnn_frame_ctrl: RTL

Frame-level sequencer for the CNN inference pipeline (downsample → data RAM → conv_cal → pool_layer). It gates frame acceptance and issues the single-cycle `cal_start` that launches convolution. It tracks convolution and pooling result counts to detect frame completion, and flags stalls and count overruns. It replaces the direct RAM-full→`cal_start` connection and lets a host enable, monitor and recover the pipeline.

---
 rtl/cnn_frame_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cnn_frame_ctrl.sv
// Frame-level sequencer for the CNN pipeline: gates frame acceptance, launches cal_start,
// tracks conv/pool result beats, flags stalls and overruns. `CNN_CTRL_STATS_EN adds frame/drop counters.
module cnn_frame_ctrl #(
    parameter int CONV_RSLT_NUM = 576,
    parameter int POOL_RSLT_NUM = 144,
    parameter int TIMEOUT       = 65535,
    parameter int CW            = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        frame_done,
    input  logic        conv_rslt_act_vld,
    input  logic        pool_data_vld,
    input  logic        err_clr,
    output logic        cal_start,
    output logic        frame_ready,
    output logic        busy,
    output logic        frame_irq,
    output logic        err_timeout,
    output logic        err_ovf,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_START, S_CONV, S_DRAIN, S_DONE, S_ERR
    } state_t;

    localparam logic [CW-1:0] CONV_MAX = CW'(CONV_RSLT_NUM);
    localparam logic [CW-1:0] POOL_MAX = CW'(POOL_RSLT_NUM);
    localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT);

    state_t        state, state_nxt;
    logic [CW-1:0] conv_cnt, pool_cnt, to_cnt;
    logic          counting, any_beat, conv_full, pool_full;
    logic          conv_last, pool_done, stall;

    always_comb begin
        counting  = (state == S_CONV) || (state == S_DRAIN);
        any_beat  = conv_rslt_act_vld || pool_data_vld;
        conv_full = (conv_cnt == CONV_MAX);
        pool_full = (pool_cnt == POOL_MAX);
        conv_last = conv_rslt_act_vld && (conv_cnt == CONV_MAX - 1'b1);
        // DRAIN also completes when the pool count was already reached during CONV
        pool_done = pool_full || (pool_data_vld && (pool_cnt == POOL_MAX - 1'b1));
        stall     = counting && !any_beat && (to_cnt == TO_MAX - 1'b1);
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_WAIT;
            S_WAIT:  begin
                if (frame_done)  state_nxt = S_START;
                else if (!en)    state_nxt = S_IDLE;
            end
            S_START: state_nxt = S_CONV;
            S_CONV:  begin
                if (stall)          state_nxt = S_ERR;
                else if (conv_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pool_done)      state_nxt = S_DONE;
                else if (stall)     state_nxt = S_ERR;
            end
            S_DONE:  state_nxt = en ? S_WAIT : S_IDLE;
            S_ERR:   if (err_clr) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cal_start   <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            frame_irq   <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
            conv_cnt    <= '0;
            pool_cnt    <= '0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            cal_start   <= (state_nxt == S_START);
            frame_ready <= (state_nxt == S_WAIT);
            busy        <= (state_nxt == S_START) || (state_nxt == S_CONV) || (state_nxt == S_DRAIN);
            frame_irq   <= (state_nxt == S_DONE);

            if (state_nxt == S_START) begin
                conv_cnt <= '0;
                pool_cnt <= '0;
                to_cnt   <= '0;
            end else if (counting) begin
                if (conv_rslt_act_vld && !conv_full) conv_cnt <= conv_cnt + 1'b1;
                if (pool_data_vld && !pool_full)     pool_cnt <= pool_cnt + 1'b1;
                to_cnt <= any_beat ? '0 : to_cnt + 1'b1;
            end

            if (err_clr) begin
                err_timeout <= 1'b0;
                err_ovf     <= 1'b0;
            end
            if (counting && state_nxt == S_ERR)
                err_timeout <= 1'b1;
            if (counting && ((conv_rslt_act_vld && conv_full) || (pool_data_vld && pool_full)))
                err_ovf <= 1'b1;
        end
    end

`ifdef CNN_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (state_nxt == S_DONE)
                frame_cnt <= frame_cnt + 1'b1;
            if (frame_done && state != S_WAIT && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule
